shared_ram_arb: RTL and testbench

Two-port arbiter that shares one single-port synchronous work RAM between the 68000 and the i8751 MCU on Big Fighter boards. The 68000 port is driven from the shared-RAM chip select decoded by the 68000 memory map. The MCU port comes from the MCU external-data bus. The block sequences each access through request, RAM cycle, data capture and acknowledge. It grants competing requests round-robin and presents byte-lane write enables to the RAM.

---
 rtl/shared_ram_arb_if.sv | 46 ++++
 rtl/shared_ram_arb.sv | 119 +++++++++++
 tb/tb_shared_ram_arb.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_ram_arb_if.sv
// Shared work-RAM bus: 68000 port, MCU port and the single-port RAM side.
// The arbiter uses the slave modport; requesters and RAM use master.
interface shared_ram_arb_if #(
  parameter int ADDR_W = 13
);
  logic              m68k_req;
  logic              m68k_rw;
  logic [ADDR_W-1:0] m68k_addr;
  logic              m68k_uds_n;
  logic              m68k_lds_n;
  logic [15:0]       m68k_din;
  logic [15:0]       m68k_dout;
  logic              m68k_ack;

  logic              mcu_req;
  logic              mcu_we;
  logic [ADDR_W:0]   mcu_addr;
  logic [7:0]        mcu_din;
  logic [7:0]        mcu_dout;
  logic              mcu_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic [1:0]        ram_we;
  logic [15:0]       ram_dout;

  modport slave (
    input  m68k_req, m68k_rw, m68k_addr,
    input  m68k_uds_n, m68k_lds_n, m68k_din,
    output m68k_dout, m68k_ack,
    input  mcu_req, mcu_we, mcu_addr, mcu_din,
    output mcu_dout, mcu_ack,
    output ram_addr, ram_din, ram_we,
    input  ram_dout
  );

  modport master (
    output m68k_req, m68k_rw, m68k_addr,
    output m68k_uds_n, m68k_lds_n, m68k_din,
    input  m68k_dout, m68k_ack,
    output mcu_req, mcu_we, mcu_addr, mcu_din,
    input  mcu_dout, mcu_ack,
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/shared_ram_arb.sv
// Round-robin 68000/i8751 arbiter for the shared single-port work RAM.
// Define SHARED_RAM_MCU_EN to enable the MCU port (68k-only otherwise).
module shared_ram_arb #(
  parameter int ADDR_W = 13
) (
  input  logic clk_sys,
  input  logic reset_n,
  shared_ram_arb_if.slave bus
);

`ifdef SHARED_RAM_MCU_EN
  localparam logic MCU_EN = 1'b1;
`else
  localparam logic MCU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_n;
  logic   owner;
  logic   last;
  logic   lane;
  logic   m_req;
  logic   u_req;
  logic   own_req;
  logic   gnt;
  logic   gnt_mcu;

  always_comb begin
    m_req   = bus.m68k_req;
    u_req   = MCU_EN & bus.mcu_req;
    own_req = owner ? u_req : m_req;
    // On contention the side that did not finish last wins
    gnt_mcu = u_req & (~m_req | ~last);
    gnt     = 1'b0;
    state_n = state;
    unique case (state)
      IDLE: begin
        if (m_req | u_req) begin
          gnt     = 1'b1;
          state_n = ACC;
        end
      end
      ACC:  state_n = WAIT;
      WAIT: state_n = own_req ? DONE : IDLE;
      DONE: if (!own_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      owner         <= 1'b0;
      last          <= 1'b1;
      lane          <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_din   <= '0;
      bus.ram_we    <= 2'b00;
      bus.m68k_ack  <= 1'b0;
      bus.m68k_dout <= '0;
      bus.mcu_ack   <= 1'b0;
      bus.mcu_dout  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt) begin
            owner <= gnt_mcu;
            if (gnt_mcu) begin
              lane         <= bus.mcu_addr[0];
              bus.ram_addr <= bus.mcu_addr[ADDR_W:1];
              bus.ram_din  <= {bus.mcu_din, bus.mcu_din};
              // Big-endian: even byte address is the high lane
              bus.ram_we   <= !bus.mcu_we ? 2'b00 :
                              bus.mcu_addr[0] ? 2'b01 : 2'b10;
            end else begin
              bus.ram_addr <= bus.m68k_addr;
              bus.ram_din  <= bus.m68k_din;
              bus.ram_we   <= bus.m68k_rw ? 2'b00 :
                              {~bus.m68k_uds_n, ~bus.m68k_lds_n};
            end
          end
        end
        ACC: bus.ram_we <= 2'b00;
        WAIT: begin
          last <= owner;
          if (own_req) begin
            if (owner) begin
              bus.mcu_ack  <= 1'b1;
              bus.mcu_dout <= lane ? bus.ram_dout[7:0]
                                   : bus.ram_dout[15:8];
            end else begin
              bus.m68k_ack  <= 1'b1;
              bus.m68k_dout <= bus.ram_dout;
            end
          end
        end
        DONE: begin
          if (!own_req) begin
            bus.m68k_ack <= 1'b0;
            bus.mcu_ack  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_ram_arb.sv
// Self-checking bench for shared_ram_arb: vector table plus corner sequences.
// Follows SHARED_RAM_MCU_EN the same way as the design.
module tb_shared_ram_arb;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  shared_ram_arb_if #(.ADDR_W(AW)) bus ();

  shared_ram_arb #(.ADDR_W(AW)) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  logic [15:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.ram_we[1] === 1'b1) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
    if (bus.ram_we[0] === 1'b1) mem[bus.ram_addr][7:0] <= bus.ram_din[7:0];
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          mcu;
    bit          wr;
    logic [13:0] addr;
    logic [1:0]  strb_n;
    logic [15:0] din;
    logic [12:0] e_addr;
    logic [1:0]  e_we;
    logic [15:0] e_din;
    logic [15:0] e_dout;
  } vec_t;

  typedef struct {
    bit          mcu;
    bit          chk_d;
    logic [15:0] d;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.m68k_ack === 1'b1 && bus.mcu_ack === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL both_acks: got 11 want not 11");
    end
  end

  function automatic vec_t mv(input bit wr, input logic [12:0] a,
                              input logic [1:0] sn, input logic [15:0] d,
                              input logic [1:0] ew, input logic [15:0] ed);
    vec_t v;
    v.mcu = 1'b0;
    v.wr = wr;
    v.addr = {1'b0, a};
    v.strb_n = sn;
    v.din = d;
    v.e_addr = a;
    v.e_we = ew;
    v.e_din = d;
    v.e_dout = ed;
    return v;
  endfunction

  function automatic vec_t uv(input bit wr, input logic [13:0] a,
                              input logic [7:0] d, input logic [1:0] ew,
                              input logic [15:0] ed);
    vec_t v;
    v.mcu = 1'b1;
    v.wr = wr;
    v.addr = a;
    v.strb_n = 2'b11;
    v.din = {8'h00, d};
    v.e_addr = a[13:1];
    v.e_we = ew;
    v.e_din = {d, d};
    v.e_dout = ed;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    if (!v.mcu) begin
      bus.m68k_rw = !v.wr;
      bus.m68k_addr = v.addr[12:0];
      bus.m68k_uds_n = v.strb_n[1];
      bus.m68k_lds_n = v.strb_n[0];
      bus.m68k_din = v.din;
      bus.m68k_req = 1'b1;
    end else begin
      bus.mcu_we = v.wr;
      bus.mcu_addr = v.addr;
      bus.mcu_din = v.din[7:0];
      bus.mcu_req = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    drive(v);
    sb.push_back('{mcu: v.mcu, chk_d: !v.wr, d: v.e_dout});
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d ram_addr", idx), bus.ram_addr, v.e_addr);
        chk($sformatf("v%0d ram_we", idx), bus.ram_we, v.e_we);
        if (v.wr) chk($sformatf("v%0d ram_din", idx), bus.ram_din, v.e_din);
      end
      if (k == 2) chk($sformatf("v%0d we_pulse", idx), bus.ram_we, 2'b00);
      if ((v.mcu ? bus.mcu_ack : bus.m68k_ack) === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk($sformatf("v%0d latency", idx), lat, 3);
    e = sb.pop_front();
    if (got && e.chk_d) begin
      if (e.mcu) chk($sformatf("v%0d mcu_dout", idx), bus.mcu_dout, e.d);
      else chk($sformatf("v%0d m68k_dout", idx), bus.m68k_dout, e.d);
    end
    bus.m68k_req = 1'b0;
    bus.mcu_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d ack_drop", idx), {bus.m68k_ack, bus.mcu_ack}, 2'b00);
  endtask

  task automatic do_reset();
    bus.m68k_req = 1'b0;
    bus.mcu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    bit   got;
    bit   m_seen;
    exp_t e;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem[13'h0123] = 16'hBEEF;
    mem[13'h1FFF] = 16'hC0DE;
    bus.m68k_req = 1'b0;
    bus.m68k_rw = 1'b1;
    bus.m68k_addr = '0;
    bus.m68k_uds_n = 1'b1;
    bus.m68k_lds_n = 1'b1;
    bus.m68k_din = '0;
    bus.mcu_req = 1'b0;
    bus.mcu_we = 1'b0;
    bus.mcu_addr = '0;
    bus.mcu_din = '0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ram_addr", bus.ram_addr, 0);
    chk("rst ram_din", bus.ram_din, 0);
    chk("rst ram_we", bus.ram_we, 0);
    chk("rst acks", {bus.m68k_ack, bus.mcu_ack}, 0);
    chk("rst m68k_dout", bus.m68k_dout, 0);
    chk("rst mcu_dout", bus.mcu_dout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back(mv(0, 13'h0123, 2'b00, 16'h0000, 2'b00, 16'hBEEF));
    vecs.push_back(mv(1, 13'h0123, 2'b10, 16'h12AB, 2'b01, 16'h0000));
    vecs.push_back(mv(0, 13'h0123, 2'b00, 16'h0000, 2'b00, 16'hBEAB));
    vecs.push_back(mv(0, 13'h0123, 2'b10, 16'h0000, 2'b00, 16'hBEAB));
    vecs.push_back(mv(1, 13'h0010, 2'b00, 16'h1234, 2'b11, 16'h0000));
    vecs.push_back(mv(0, 13'h0010, 2'b00, 16'h0000, 2'b00, 16'h1234));
    vecs.push_back(mv(1, 13'h0010, 2'b01, 16'hFF00, 2'b10, 16'h0000));
    vecs.push_back(mv(0, 13'h0010, 2'b00, 16'h0000, 2'b00, 16'hFF34));
    vecs.push_back(mv(0, 13'h1FFF, 2'b00, 16'h0000, 2'b00, 16'hC0DE));
    vecs.push_back(mv(1, 13'h1FFF, 2'b00, 16'h5555, 2'b11, 16'h0000));
    vecs.push_back(mv(0, 13'h1FFF, 2'b00, 16'h0000, 2'b00, 16'h5555));
`ifdef SHARED_RAM_MCU_EN
    vecs.push_back(mv(1, 13'h0123, 2'b00, 16'hBEEF, 2'b11, 16'h0000));
    vecs.push_back(uv(1, 14'h0246, 8'h5A, 2'b10, 16'h0000));
    vecs.push_back(uv(0, 14'h0247, 8'h00, 2'b00, 16'h00EF));
    vecs.push_back(uv(0, 14'h0246, 8'h00, 2'b00, 16'h005A));
    vecs.push_back(uv(1, 14'h0247, 8'h77, 2'b01, 16'h0000));
    vecs.push_back(mv(0, 13'h0123, 2'b00, 16'h0000, 2'b00, 16'h5A77));
    vecs.push_back(uv(0, 14'h3FFF, 8'h00, 2'b00, 16'h0055));
`endif
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

`ifdef SHARED_RAM_MCU_EN
    // Contention from reset: 68k first, then strict alternation
    do_reset();
    bus.m68k_rw = 1'b1;
    bus.m68k_addr = 13'h0010;
    bus.mcu_we = 1'b0;
    bus.mcu_addr = 14'h0021;
    for (int g = 0; g < 5; g++)
      sb.push_back('{mcu: g[0], chk_d: 1'b1,
                     d: g[0] ? 16'h0034 : 16'hFF34});
    bus.m68k_req = 1'b1;
    bus.mcu_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12 && !got; k++) begin
        @(negedge clk);
        if (bus.m68k_ack === 1'b1 || bus.mcu_ack === 1'b1) begin
          got = 1'b1;
          lat = k;
        end
      end
      e = sb.pop_front();
      chk($sformatf("arb%0d owner", g), {bus.m68k_ack, bus.mcu_ack},
          e.mcu ? 2'b01 : 2'b10);
      chk($sformatf("arb%0d latency", g), lat, 3);
      chk($sformatf("arb%0d dout", g),
          e.mcu ? {8'h00, bus.mcu_dout} : bus.m68k_dout, e.d);
      if (g == 4) begin
        bus.m68k_req = 1'b0;
        bus.mcu_req = 1'b0;
      end else if (e.mcu) bus.mcu_req = 1'b0;
      else bus.m68k_req = 1'b0;
      @(negedge clk);
      chk($sformatf("arb%0d release", g), {bus.m68k_ack, bus.mcu_ack}, 0);
      bus.m68k_req = (g != 4);
      bus.mcu_req = (g != 4);
    end
`endif

    // Aborted 68k write with an MCU request pending
    do_reset();
    bus.m68k_rw = 1'b0;
    bus.m68k_addr = 13'h0200;
    bus.m68k_uds_n = 1'b0;
    bus.m68k_lds_n = 1'b0;
    bus.m68k_din = 16'hCAFE;
    bus.m68k_req = 1'b1;
`ifdef SHARED_RAM_MCU_EN
    bus.mcu_we = 1'b0;
    bus.mcu_addr = 14'h0400;
    bus.mcu_req = 1'b1;
`endif
    @(negedge clk);
    chk("abort ram_we", bus.ram_we, 2'b11);
    chk("abort ram_addr", bus.ram_addr, 13'h0200);
    bus.m68k_req = 1'b0;
    m_seen = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (bus.m68k_ack === 1'b1) m_seen = 1'b1;
      if (!got && bus.mcu_ack === 1'b1) begin
        got = 1'b1;
        lat = k;
        chk("abort mcu_dout", bus.mcu_dout, 8'hCA);
        bus.mcu_req = 1'b0;
      end
    end
    chk("abort no m68k_ack", m_seen, 1'b0);
`ifdef SHARED_RAM_MCU_EN
    chk("abort mcu latency", lat, 6);
`else
    chk("abort mcu ignored", got, 1'b0);
`endif
    run_vec(mv(0, 13'h0200, 2'b00, 16'h0000, 2'b00, 16'hCAFE), 100);

    // Asynchronous reset in the middle of WAIT
    bus.m68k_rw = 1'b1;
    bus.m68k_addr = 13'h1FFF;
    bus.m68k_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("areset ram_addr", bus.ram_addr, 0);
    chk("areset ram_we", bus.ram_we, 0);
    chk("areset ram_din", bus.ram_din, 0);
    chk("areset acks", {bus.m68k_ack, bus.mcu_ack}, 0);
    chk("areset m68k_dout", bus.m68k_dout, 0);
    chk("areset mcu_dout", bus.mcu_dout, 0);
    bus.m68k_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(mv(0, 13'h1FFF, 2'b00, 16'h0000, 2'b00, 16'h5555), 101);

`ifndef SHARED_RAM_MCU_EN
    // MCU port inert: held write request must never reach the RAM
    bus.mcu_we = 1'b1;
    bus.mcu_addr = 14'h0000;
    bus.mcu_din = 8'hFF;
    bus.mcu_req = 1'b1;
    run_vec(mv(0, 13'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000), 102);
    bus.mcu_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("nomcu mcu_ack", bus.mcu_ack, 1'b0);
    chk("nomcu mcu_dout", bus.mcu_dout, 8'h00);
    chk("nomcu ram_we", bus.ram_we, 2'b00);
    run_vec(mv(0, 13'h0010, 2'b00, 16'h0000, 2'b00, 16'hFF34), 103);
    bus.mcu_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
